led_fade_pwm: RTL and testbench

- Downstream stage of the free-running LED blink counter.
- Takes per-LED on/off request levels and drives the physical LED pins with PWM.
- On each request edge, brightness ramps smoothly up or down (fade) instead of switching hard.
- Sits between the blink/pattern logic and the board LED pins. Runs entirely on the 50 MHz system clock.

---
 rtl/led_fade_pwm.sv | 104 ++++++++++
 tb/tb_led_fade_pwm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// Per-channel LED fader: each request edge ramps brightness up/down one step per fade tick, driven out as PWM.
// Optional LED_FADE_GAMMA_EN maps level to a squared (perceptual) duty; default build uses duty = level.
module led_fade_ch #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_tick,
  input  logic                i_req,
  input  logic                i_enable,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led,
  output logic                o_busy
);
  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] w_duty;
  logic                r_led;

  // Saturating ramp; direction follows the request at every tick, so reversal never jumps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= '0;
    end else if (i_tick) begin
      if (i_req && r_level != MAX)       r_level <= r_level + 1'b1;
      else if (!i_req && r_level != '0)  r_level <= r_level - 1'b1;
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] w_sq;
  assign w_sq   = {{PWM_BITS{1'b0}}, r_level} * {{PWM_BITS{1'b0}}, r_level};
  // Full scale is pinned so the top level stays constantly on.
  assign w_duty = (r_level == MAX) ? MAX : w_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty = r_level;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_led <= 1'b0;
    else        r_led <= i_enable & (w_duty > i_pwm_cnt);
  end

  assign o_led  = r_led;
  assign o_busy = i_req ? (r_level != MAX) : (r_level != '0);
endmodule

module led_fade_pwm #(
  parameter int N_CH     = 8,
  parameter int PWM_BITS = 8,
  parameter int FADE_DIV = 24414
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N_CH-1:0] led_req,
  output logic [N_CH-1:0] led_out,
  output logic            fade_busy
);
  localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - 1'b1;

  logic [N_CH-1:0]     r_req_q;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                r_busy;
  logic                w_tick;
  logic [N_CH-1:0]     w_busy;

  assign w_tick = (r_div_cnt == DIV_LAST);

  // Divider and PWM counter free-run independently of enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_q   <= '0;
      r_div_cnt <= '0;
      r_pwm_cnt <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_req_q   <= led_req;
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_pwm_cnt <= (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;
      r_busy    <= |w_busy;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    led_fade_ch #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_tick    (w_tick),
      .i_req     (r_req_q[g]),
      .i_enable  (enable),
      .i_pwm_cnt (r_pwm_cnt),
      .o_led     (led_out[g]),
      .o_busy    (w_busy[g])
    );
  end

  assign fade_busy = r_busy;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized + directed bench for led_fade_pwm; a time-based reference model feeds a scoreboard queue.
module tb_led_fade_pwm;
  localparam int N_CH = 8;
  localparam int PW   = 4;
  localparam int MAX  = (1 << PW) - 1;
  localparam int FDIV = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic [N_CH-1:0] led_req;
  logic [N_CH-1:0] led_out;
  logic            fade_busy;

  led_fade_pwm #(.N_CH(N_CH), .PWM_BITS(PW), .FADE_DIV(FDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .led_req   (led_req),
    .led_out   (led_out),
    .fade_busy (fade_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;

  logic [N_CH:0]   exp_q[$];
  int              m_lvl[N_CH];
  logic [N_CH-1:0] m_req;
  int              m_t;
  logic [N_CH-1:0] m_eo;
  logic            m_eb;
  logic [N_CH:0]   mon_e;

  function automatic int duty(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l == MAX) ? MAX : ((l * l) >> PW);
`else
    return l;
`endif
  endfunction

  // Reference: PWM phase and fade ticks follow from the cycle count since reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_eo = '0;
      m_eb = 1'b0;
      for (int i = 0; i < N_CH; i++) m_lvl[i] = 0;
      m_req = '0;
      m_t   = 0;
    end else begin
      m_eb = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_eo[i] = enable && (duty(m_lvl[i]) > (m_t % MAX));
        if (m_req[i] ? (m_lvl[i] != MAX) : (m_lvl[i] != 0)) m_eb = 1'b1;
      end
      if (m_t % FDIV == FDIV - 1)
        for (int i = 0; i < N_CH; i++) begin
          if (m_req[i] && m_lvl[i] < MAX)      m_lvl[i] = m_lvl[i] + 1;
          else if (!m_req[i] && m_lvl[i] > 0)  m_lvl[i] = m_lvl[i] - 1;
        end
      m_req = led_req;
      m_t   = m_t + 1;
    end
    exp_q.push_back({m_eo, m_eb});
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (led_out !== mon_e[N_CH:1]) begin
        errors++;
        $display("FAIL led_out @%0t: got %b expected %b", $time, led_out, mon_e[N_CH:1]);
      end
      checks++;
      if (fade_busy !== mon_e[0]) begin
        errors++;
        $display("FAIL fade_busy @%0t: got %b expected %b", $time, fade_busy, mon_e[0]);
      end
    end
    if (tmo_cnt != tmo_seen) begin
      tmo_seen++;
      checks++;
      errors++;
      $display("FAIL level_wait timeout @%0t: got %0d expected target reached", $time, m_lvl[0]);
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_lvl(input int v);
    for (int k = 0; k < 200 && m_lvl[0] != v; k++) step();
    if (m_lvl[0] != v) tmo_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; led_req = 8'hFF;
    step(3);
    rst_n = 1'b1;
    step(70);
    // All dark, then ramp channel 0 alone to full.
    led_req = 8'h00;
    step(70);
    led_req = 8'h01;
    wait_lvl(5);
    step(6);
    wait_lvl(15);
    step(20);
    // Reversal while rising at level 8.
    led_req = 8'h00;
    wait_lvl(0);
    led_req = 8'h01;
    wait_lvl(8);
    led_req = 8'h00;
    step(45);
    // Enable gating mid-ramp.
    led_req = 8'h01;
    wait_lvl(10);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    step(40);
    // Reset mid-fade.
    led_req = 8'h00;
    wait_lvl(0);
    led_req = 8'h03;
    wait_lvl(6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(80);
    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(7) == 0)   led_req = N_CH'($urandom);
      if ($urandom_range(15) == 0)  enable  = ~enable;
      rst_n = ($urandom_range(149) != 0);
      step();
    end
    rst_n = 1'b1;
    step(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
